// File: rtl/dram_sched_pkg.sv
// Shared types and defaults for the DRAM access scheduler: FSM states, grant
// codes, refresh timing and the CAS bank decode.
package dram_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REF1 = 3'd1,
        REF2 = 3'd2,
        REF3 = 3'd3,
        FIL1 = 3'd4,
        FIL2 = 3'd5,
        FIL3 = 3'd6,
        CPU  = 3'd7
    } schedState_t;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_CPU  = 2'd1;
    localparam logic [1:0] GRANT_REF  = 2'd2;
    localparam logic [1:0] GRANT_FILL = 2'd3;

    localparam int REF_PERIOD_DEF   = 104;
    localparam int REF_MAX_PEND_DEF = 4;
    localparam int REF_URGENT_DEF   = 2;
    localparam int PEND_W           = 3;

    // Returns {cas1, cas0} for a single-bank access.
    function automatic logic [1:0] bankCas(input logic bank);
        return bank ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh request generator: free-running period counter feeding a saturating
// pending-refresh count with a sticky overflow flag.
module dram_refresh_timer
    import dram_sched_pkg::*;
#(
    parameter int REF_PERIOD   = REF_PERIOD_DEF,
    parameter int REF_MAX_PEND = REF_MAX_PEND_DEF
) (
    input  logic              C7M,
    input  logic              nRES,
    input  logic              dec,
    output logic [PEND_W-1:0] pend,
    output logic              refOvf
);

    localparam int CNT_W = $clog2(REF_PERIOD);

    logic [CNT_W-1:0]  count;
    logic              tick;
    logic [PEND_W-1:0] pendNext;

    assign tick = (count == CNT_W'(REF_PERIOD - 1));

    // A wrap and a completed refresh in the same cycle cancel out.
    always_comb begin
        pendNext = pend;
        if (tick && !dec) begin
            if (pend != PEND_W'(REF_MAX_PEND))
                pendNext = pend + 1'b1;
        end else if (dec && !tick && pend != '0) begin
            pendNext = pend - 1'b1;
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            count  <= '0;
            pend   <= '0;
            refOvf <= 1'b0;
        end else begin
            count  <= tick ? '0 : count + 1'b1;
            pend   <= pendNext;
            refOvf <= refOvf | (pendNext == PEND_W'(REF_MAX_PEND));
        end
    end

endmodule

// File: rtl/dram_access_sched.sv
// DRAM sequencer: arbitrates the shared RAS/CAS/address-mux path between the
// 6502 slot access, CBR refresh and the fill port, with registered strobes.
module dram_access_sched
    import dram_sched_pkg::*;
#(
    parameter int REF_PERIOD   = REF_PERIOD_DEF,
    parameter int REF_MAX_PEND = REF_MAX_PEND_DEF,
    parameter int REF_URGENT   = REF_URGENT_DEF
) (
    input  logic       C7M,
    input  logic       nRES,
    input  logic [2:0] S,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic       cpu_bank,
    input  logic       fill_req,
    input  logic       fill_we,
    input  logic       fill_bank,
    output logic       fill_ack,
    output logic       ras,
    output logic       cas0,
    output logic       cas1,
    output logic       col_sel,
    output logic       dram_we,
    output logic [1:0] grant,
    output logic       ref_ovf,
    output logic [2:0] dbgState
);

    schedState_t       state, stateNext;
    logic [PEND_W-1:0] pend;
    logic              refDone;
    logic              cpuStart;
    logic              cpuWeR, cpuBankR;
    logic              bgSlot;
    logic              rasN, colN, weN, ackN;
    logic [1:0]        casN;
    logic [1:0]        grantN;

    assign refDone  = (state == REF3);
    assign bgSlot   = (S == 3'd1) || (S == 3'd0);
    assign dbgState = state;

    dram_refresh_timer #(
        .REF_PERIOD  (REF_PERIOD),
        .REF_MAX_PEND(REF_MAX_PEND)
    ) uTimer (
        .C7M   (C7M),
        .nRES  (nRES),
        .dec   (refDone),
        .pend  (pend),
        .refOvf(ref_ovf)
    );

    // Outputs are computed for the next state so every strobe is a plain flop.
    always_comb begin
        stateNext = IDLE;
        rasN      = 1'b0;
        casN      = 2'b00;
        colN      = 1'b0;
        weN       = 1'b0;
        ackN      = 1'b0;
        grantN    = GRANT_NONE;
        cpuStart  = 1'b0;
        if (S == 3'd4 && cpu_req) begin
            stateNext = CPU;
            rasN      = 1'b1;
            grantN    = GRANT_CPU;
            cpuStart  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bgSlot) begin
                        if (pend >= PEND_W'(REF_URGENT) ||
                            (!(S == 3'd1 && fill_req) && pend != '0)) begin
                            stateNext = REF1;
                            casN      = 2'b11;
                            grantN    = GRANT_REF;
                        end else if (S == 3'd1 && fill_req) begin
                            stateNext = FIL1;
                            rasN      = 1'b1;
                            grantN    = GRANT_FILL;
                        end
                    end
                end
                REF1: begin
                    stateNext = REF2;
                    rasN      = 1'b1;
                    casN      = 2'b11;
                    grantN    = GRANT_REF;
                end
                REF2: begin
                    stateNext = REF3;
                    rasN      = 1'b1;
                    grantN    = GRANT_REF;
                end
                FIL1: begin
                    stateNext = FIL2;
                    rasN      = 1'b1;
                    colN      = 1'b1;
                    casN      = bankCas(fill_bank);
                    weN       = fill_we;
                    grantN    = GRANT_FILL;
                end
                FIL2: begin
                    stateNext = FIL3;
                    ackN      = 1'b1;
                    grantN    = GRANT_FILL;
                end
                CPU: begin
                    // Any phase other than S5/S6 (S7 end or a PHI1 resync) closes the access.
                    if (S == 3'd5 || S == 3'd6) begin
                        stateNext = CPU;
                        rasN      = 1'b1;
                        colN      = 1'b1;
                        weN       = cpuWeR;
                        casN      = (cpuWeR && S == 3'd5) ? 2'b00 : bankCas(cpuBankR);
                        grantN    = GRANT_CPU;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge C7M or negedge nRES) begin
        if (!nRES) begin
            state    <= IDLE;
            ras      <= 1'b0;
            cas0     <= 1'b0;
            cas1     <= 1'b0;
            col_sel  <= 1'b0;
            dram_we  <= 1'b0;
            fill_ack <= 1'b0;
            grant    <= GRANT_NONE;
            cpuWeR   <= 1'b0;
            cpuBankR <= 1'b0;
        end else begin
            state    <= stateNext;
            ras      <= rasN;
            cas0     <= casN[0];
            cas1     <= casN[1];
            col_sel  <= colN;
            dram_we  <= weN;
            fill_ack <= ackN;
            grant    <= grantN;
            if (cpuStart) begin
                cpuWeR   <= cpu_we;
                cpuBankR <= cpu_bank;
            end
        end
    end

endmodule
